// File: rtl/ysyx_22050598_arb_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   M_IFU/M_LSU : master index constants (owner / last_grant encoding)
//   ARB_AW/DW   : default address and data widths
package ysyx_22050598_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SREQ  = 2'd1,
        SRESP = 2'd2
    } arb_state_e;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    localparam int unsigned ARB_AW = 32;
    localparam int unsigned ARB_DW = 64;

endpackage

// File: rtl/ysyx_22050598_rr_pick2.sv
// Combinational two-way round-robin pick.
//   i_vld0/i_vld1 : request valids of master 0 / master 1
//   i_last        : index of the master granted most recently
//   o_gnt_vld     : some master is requesting
//   o_gnt_idx     : index of the winning master (meaningful when o_gnt_vld)
module ysyx_22050598_rr_pick2
    import ysyx_22050598_arb_pkg::*;
(
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_last,
    output logic o_gnt_vld,
    output logic o_gnt_idx
);

    always_comb begin
        o_gnt_vld = i_vld0 | i_vld1;
        o_gnt_idx = M_IFU;
        if (i_vld0 && i_vld1) begin
            // Tie: the master that did not win last time goes next.
            o_gnt_idx = ~i_last;
        end else if (i_vld1) begin
            o_gnt_idx = M_LSU;
        end
    end

endmodule

// File: rtl/ysyx_22050598_mem_arbiter.sv
// Two-master, single-outstanding arbiter sharing one memory port between
// the IFU (master 0) and the LSU (master 1).
//   clk, rst              : clock, synchronous active-high reset
//   mN_req_*              : master N request channel (valid/ready + fields)
//   mN_resp_*             : master N response channel (valid/ready + rdata)
//   s_req_*               : downstream request channel, fields registered
//   s_resp_*              : downstream response channel
// Grant is round-robin and held from request acceptance until the response
// handshake completes.
module ysyx_22050598_mem_arbiter
    import ysyx_22050598_arb_pkg::*;
#(
    parameter int unsigned AW = ARB_AW,
    parameter int unsigned DW = ARB_DW
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic            m0_req_wen,
    input  logic [AW-1:0]   m0_req_addr,
    input  logic [DW-1:0]   m0_req_wdata,
    input  logic [DW/8-1:0] m0_req_wstrb,
    output logic            m0_resp_valid,
    input  logic            m0_resp_ready,
    output logic [DW-1:0]   m0_resp_rdata,

    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic            m1_req_wen,
    input  logic [AW-1:0]   m1_req_addr,
    input  logic [DW-1:0]   m1_req_wdata,
    input  logic [DW/8-1:0] m1_req_wstrb,
    output logic            m1_resp_valid,
    input  logic            m1_resp_ready,
    output logic [DW-1:0]   m1_resp_rdata,

    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic            s_req_wen,
    output logic [AW-1:0]   s_req_addr,
    output logic [DW-1:0]   s_req_wdata,
    output logic [DW/8-1:0] s_req_wstrb,
    input  logic            s_resp_valid,
    output logic            s_resp_ready,
    input  logic [DW-1:0]   s_resp_rdata
);

    arb_state_e r_state;
    arb_state_e w_next;

    logic            r_last_grant;
    logic            r_owner;
    logic            r_wen;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;

    logic            w_gnt_vld;
    logic            w_gnt_idx;
    logic            w_accept;
    logic            w_resp_done;
    logic            w_owner_resp_ready;

    ysyx_22050598_rr_pick2 u_pick (
        .i_vld0    (m0_req_valid),
        .i_vld1    (m1_req_valid),
        .i_last    (r_last_grant),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    // Reset gates the accept so no master sees a handshake that the
    // request register is not going to capture.
    assign w_accept           = (r_state == IDLE) && w_gnt_vld && !rst;
    assign w_owner_resp_ready = (r_owner == M_LSU) ? m1_resp_ready : m0_resp_ready;
    assign w_resp_done        = (r_state == SRESP) && s_resp_valid && w_owner_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= M_LSU;
            r_owner      <= M_IFU;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            if (w_accept) begin
                r_owner <= w_gnt_idx;
                if (w_gnt_idx == M_LSU) begin
                    r_wen   <= m1_req_wen;
                    r_addr  <= m1_req_addr;
                    r_wdata <= m1_req_wdata;
                    r_wstrb <= m1_req_wstrb;
                end else begin
                    r_wen   <= m0_req_wen;
                    r_addr  <= m0_req_addr;
                    r_wdata <= m0_req_wdata;
                    r_wstrb <= m0_req_wstrb;
                end
            end
            if (w_resp_done) begin
                r_last_grant <= r_owner;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        s_req_valid   = 1'b0;
        s_resp_ready  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    m0_req_ready = (w_gnt_idx == M_IFU);
                    m1_req_ready = (w_gnt_idx == M_LSU);
                    w_next       = SREQ;
                end
            end
            SREQ: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    w_next = SRESP;
                end
            end
            SRESP: begin
                s_resp_ready  = w_owner_resp_ready;
                m0_resp_valid = (r_owner == M_IFU) && s_resp_valid;
                m1_resp_valid = (r_owner == M_LSU) && s_resp_valid;
                if (w_resp_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign s_req_wen     = r_wen;
    assign s_req_addr    = r_addr;
    assign s_req_wdata   = r_wdata;
    assign s_req_wstrb   = r_wstrb;

    // Read data is shared; only the owner's resp_valid qualifies it.
    assign m0_resp_rdata = s_resp_rdata;
    assign m1_resp_rdata = s_resp_rdata;

endmodule

// File: doc/ysyx_22050598_mem_arbiter.md
# ysyx_22050598_mem_arbiter

Two-master, single-outstanding arbiter that shares the core's single memory port between the IFU (master 0) and the LSU (master 1). It sits between the two pipeline memory interfaces and the downstream bus bridge. Each master uses a valid/ready request channel and a valid/ready response channel. Grant is round-robin and is held from request acceptance until the response handshake completes.

## Interface
- AW, 32, address width
- DW, 64, data width; wstrb width is DW/8
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mN_req_valid  in  1  master N (N=0,1) request valid
- mN_req_ready  out  1  master N request accepted this cycle
- mN_req_wen  in  1  1 = write, 0 = read
- mN_req_addr  in  AW  request address
- mN_req_wdata  in  DW  write data
- mN_req_wstrb  in  DW/8  byte strobes
- mN_resp_valid  out  1  response valid to master N
- mN_resp_ready  in  1  master N accepts response
- mN_resp_rdata  out  DW  read data (don't-care for writes)
- s_req_valid  out  1  downstream request valid
- s_req_ready  in  1  downstream accepts request
- s_req_wen / s_req_addr / s_req_wdata / s_req_wstrb  out  1/AW/DW/DW/8  registered request fields
- s_resp_valid  in  1  downstream response valid
- s_resp_ready  out  1  arbiter accepts response
- s_resp_rdata  in  DW  downstream read data

## Operation
- States:
  - IDLE: no transaction.
  - SREQ: drive downstream request.
  - SRESP: wait for and forward the response.
- IDLE:
  - If any mN_req_valid, pick the winner.
    - Only one valid: that master wins.
    - Both valid: the master not equal to last_grant wins.
  - Assert the winner's mN_req_ready in the same cycle, combinationally.
  - Capture wen/addr/wdata/wstrb into the request register.
  - Set owner to the winner, go to SREQ.
  - The loser's req_ready stays 0.
- SREQ:
  - s_req_valid = 1; fields come from the request register and are stable until accepted.
  - On s_req_ready: go to SRESP.
- SRESP:
  - s_resp_ready = owner's mN_resp_ready.
  - Owner's mN_resp_valid = s_resp_valid, mN_resp_rdata = s_resp_rdata, both combinational pass-through.
  - Other master's resp_valid = 0.
  - On s_resp_valid && s_resp_ready: last_grant <= owner, go to IDLE.
- All mN_req_ready are 0 outside IDLE. Only one transaction is outstanding at a time.
- A master that drops req_valid in IDLE before being granted is simply not considered; no state is kept.
- s_resp_ready = 0 in IDLE and SREQ. A response arriving there is a downstream protocol error; the arbiter does not consume it.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (master 0 wins the first tie), owner = 0, request register = 0.
  - All valid/ready outputs = 0.
- Reset has priority over every transition. Asserting rst mid-transaction returns to IDLE next edge and discards the transaction; the downstream bridge is reset by the same rst.
- Minimum latency: request accept at cycle T, s_req_valid at T+1.
  - s_req_ready at T+1 puts the FSM in SRESP at T+2.
  - A response at T+2 reaches the master at T+2 (zero-cycle pass-through).
  - Back to IDLE at T+3, earliest next accept at T+3.
- Fairness: under continuous requests from both masters, grants strictly alternate 0,1,0,1…
- Downstream back-pressure of any length on s_req_ready or mN_resp_ready holds the state. Outputs stay stable and no field changes.

## Structure
- Shared package ysyx_22050598_arb_pkg:
  - State enum (IDLE, SREQ, SRESP).
  - Master index constants (M_IFU = 0, M_LSU = 1).
  - Default widths AW/DW.
- One sub-module, ysyx_22050598_rr_pick2: combinational 2-way round-robin pick. Inputs are the two valids and last_grant; outputs are gnt_vld and gnt_idx.
- Request register, owner and last_grant are plain enabled flops in the top. Their load enable is the IDLE accept condition.

## Test plan
- Single read: m0 read addr 0x8000_0000 with s_req_ready = 1 and s_resp_valid at the next cycle (rdata 0x1122_3344_5566_7788) -> m0 sees resp_valid with that data 2 cycles after accept; m1 resp_valid stays 0.
- Tie after reset: both masters valid at cycle 0 -> m0 granted first, m1 granted at the next IDLE, then m0; over 8 transactions grants alternate exactly.
- Write pass-through: m1 write addr 0x8000_0010, wdata 0xDEAD_BEEF_0000_0001, wstrb 0x0F -> s_req fields match bit-exactly and are held through 5 cycles of s_req_ready = 0.
- Response back-pressure: owner holds resp_ready = 0 for 3 cycles -> s_resp_ready = 0 over the same cycles, the FSM stays in SRESP, and no other master is accepted.
- Mid-transaction reset: rst asserted in SREQ -> next cycle state IDLE, s_req_valid = 0, all ready outputs 0; the first grant after reset goes to m0 on a tie.
- Non-owner isolation: while m0 owns, m1 req_valid = 1 throughout -> m1_req_ready = 0 until the FSM returns to IDLE, then m1 is accepted that cycle.
